// File: rtl/regfile_mp.sv
// Multi-port integer register file with r0 tied to zero, same-cycle write bypass,
// a post-reset clearing sequencer and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NR     = 4,
  parameter int NW     = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [NR-1:0]        re,
  input  logic [NR*AW-1:0]     raddr,
  output logic [NR*DATA_W-1:0] rdata,
  output logic [NR-1:0]        rbusy,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_addr
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW:0]         r_idx;
  logic [AW:0]         w_idx_nxt;
  logic [NREGS-1:0]    r_busy;
  logic [DATA_W-1:0]   r_mem [NREGS];
  logic                w_run;

  assign w_run     = (r_state == S_RUN);
  assign init_done = w_run;

  // Sequencer: idx is one bit wider than an address so it cannot wrap early
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_INIT: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Storage: cleared one entry per cycle in INIT; later ports override earlier ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) begin
        r_mem[r_idx[AW-1:0]] <= '0;
      end else begin
        for (int j = 0; j < NW; j++) begin
          if (we[j] && (waddr[j*AW +: AW] != '0))
            r_mem[waddr[j*AW +: AW]] <= wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: write clears, allocation sets afterwards so the younger producer wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (r_state == S_RUN) begin
      for (int j = 0; j < NW; j++) begin
        if (we[j]) r_busy[waddr[j*AW +: AW]] <= 1'b0;
      end
      if (alloc_valid) r_busy[alloc_addr] <= 1'b1;
      r_busy[0] <= 1'b0;
    end
  end

  // Read ports: the highest-index matching write port supplies the bypass value
  always_comb begin
    logic              hit;
    logic [DATA_W-1:0] byp;
    logic [AW-1:0]     ra;
    rdata = '0;
    rbusy = '0;
    hit   = 1'b0;
    byp   = '0;
    ra    = '0;
    for (int i = 0; i < NR; i++) begin
      ra  = raddr[i*AW +: AW];
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NW; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == ra)) begin
          hit = 1'b1;
          byp = wdata[j*DATA_W +: DATA_W];
        end
      end
      if (w_run && re[i]) begin
        if (ra != '0) rdata[i*DATA_W +: DATA_W] = hit ? byp : r_mem[ra];
        rbusy[i] = r_busy[ra] & ~hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset/clearing sequence, then a vector table
// of read/write/bypass/scoreboard cases, then a reset issued while running.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NR     = 4;
  localparam int NW     = 2;
  localparam int AW     = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 init_done;
  logic [NW-1:0]        we;
  logic [NW*AW-1:0]     waddr;
  logic [NW*DATA_W-1:0] wdata;
  logic [NR-1:0]        re;
  logic [NR*AW-1:0]     raddr;
  logic [NR*DATA_W-1:0] rdata;
  logic [NR-1:0]        rbusy;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_addr;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.DATA_W(DATA_W), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [3:0]  re;
    logic [4:0]  ra0, ra1, ra2, ra3;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] e0, e1, e2, e3;
    logic [3:0]  eb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string nm, input int w, input int wa0, input logic [31:0] wd0,
                              input int wa1, input logic [31:0] wd1, input int r,
                              input int ra0, input int ra1, input int ra2, input int ra3,
                              input int av, input int aa,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input int eb);
    vec_t v;
    v.nm = nm;  v.we = 2'(w);  v.wa0 = 5'(wa0); v.wd0 = wd0; v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.re = 4'(r); v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.ra2 = 5'(ra2); v.ra3 = 5'(ra3);
    v.av = 1'(av); v.aa = 5'(aa);
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eb = 4'(eb);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0;
    alloc_valid = 1'b0; alloc_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input logic [4:0] a);
    re = 4'b1111;
    raddr = {a, a, a, a};
  endtask

  initial begin
    vt.push_back(mk("idle_r4",     'b00,  0, 32'h0,         0, 32'h0,    'b1111,  4, 4, 4, 4, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("wr_r5_r0",    'b11,  5, 32'hDEADBEEF,  0, 32'h1234, 'b1111,  0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("rd_r5",       'b00,  0, 32'h0,         0, 32'h0,    'b1111,  5, 5, 5, 5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 'b0000));
    vt.push_back(mk("rd_r0",       'b00,  0, 32'h0,         0, 32'h0,    'b1111,  0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("conf_r7",     'b11,  7, 32'h11,        7, 32'h22,   'b0111,  7, 7, 7, 7, 0, 0, 32'h22, 32'h22, 32'h22, 32'h0, 'b0000));
    vt.push_back(mk("rd_r7",       'b00,  0, 32'h0,         0, 32'h0,    'b1111,  7, 7, 7, 7, 0, 0, 32'h22, 32'h22, 32'h22, 32'h22, 'b0000));
    vt.push_back(mk("re_off",      'b00,  0, 32'h0,         0, 32'h0,    'b0000,  5, 5, 5, 5, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("alloc_r9_t0", 'b00,  0, 32'h0,         0, 32'h0,    'b1111,  9, 9, 9, 9, 1, 9, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("busy_r9_t1",  'b00,  0, 32'h0,         0, 32'h0,    'b1111,  9, 9, 9, 9, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b1111));
    vt.push_back(mk("busy_r9_t2",  'b00,  0, 32'h0,         0, 32'h0,    'b0101,  9, 9, 9, 9, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0101));
    vt.push_back(mk("busy_r9_t3",  'b00,  0, 32'h0,         0, 32'h0,    'b1111,  9, 9, 9, 9, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b1111));
    vt.push_back(mk("wr_r9_t4",    'b10,  0, 32'h0,         9, 32'hABCD, 'b1111,  9, 9, 9, 9, 0, 0, 32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD, 'b0000));
    vt.push_back(mk("rd_r9_t5",    'b00,  0, 32'h0,         0, 32'h0,    'b1111,  9, 9, 9, 9, 0, 0, 32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD, 'b0000));
    vt.push_back(mk("alloc_wr_r3", 'b01,  3, 32'h33,        0, 32'h0,    'b1111,  3, 3, 3, 3, 1, 3, 32'h33, 32'h33, 32'h33, 32'h33, 'b0000));
    vt.push_back(mk("rd_r3_busy",  'b00,  0, 32'h0,         0, 32'h0,    'b1111,  3, 3, 3, 3, 0, 0, 32'h33, 32'h33, 32'h33, 32'h33, 'b1111));
    vt.push_back(mk("alloc_r0",    'b00,  0, 32'h0,         0, 32'h0,    'b1111,  0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("rd_r0_after", 'b00,  0, 32'h0,         0, 32'h0,    'b1111,  0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 'b0000));
    vt.push_back(mk("split_wr",    'b11, 10, 32'hA,        11, 32'hB,    'b1111, 10, 11, 10, 11, 0, 0, 32'hA, 32'hB, 32'hA, 32'hB, 'b0000));
    vt.push_back(mk("mixed",       'b00,  0, 32'h0,         0, 32'h0,    'b1111,  3, 9, 5, 7, 0, 0, 32'h33, 32'hABCD, 32'hDEADBEEF, 32'h22, 'b0001));
    vt.push_back(mk("rd_split",    'b00,  0, 32'h0,         0, 32'h0,    'b1111, 10, 11, 11, 10, 0, 0, 32'hA, 32'hB, 32'hB, 32'hA, 'b0000));

    // Reset held for a few cycles; outputs must be quiet while in INIT
    idle();
    rst = 1'b1;
    repeat (3) tick();
    read_all(5'd1);
    raddr = {5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("rst_init_done", 128'(init_done), 128'(1'b0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    chk("rst_rbusy", 128'(rbusy), 128'(0));
    tick();
    idle();

    // Partial clearing, then a reset at cycle 10 restarts the sequence
    for (int c = 0; c < 10; c++) begin
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("seq1_init_done_c%0d", c), 128'(init_done), 128'(1'b0));
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("seq1_rst_c10", 128'(init_done), 128'(1'b0));
    tick();

    for (int c = 0; c < 34; c++) begin
      rst = 1'b0;
      idle();
      if (c == 5) begin
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h55};
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        read_all(5'd4);
      end
      @(negedge clk);
      chk($sformatf("seq2_init_done_c%0d", c), 128'(init_done), 128'(c >= 32));
      if (c == 5) begin
        chk("init_rdata_zero", 128'(rdata), 128'(0));
        chk("init_rbusy_zero", 128'(rbusy), 128'(0));
      end
      tick();
    end

    // Vector table in RUN; each row is one cycle
    for (int k = 0; k < vt.size(); k++) begin
      we = vt[k].we;
      waddr = {vt[k].wa1, vt[k].wa0};
      wdata = {vt[k].wd1, vt[k].wd0};
      re = vt[k].re;
      raddr = {vt[k].ra3, vt[k].ra2, vt[k].ra1, vt[k].ra0};
      alloc_valid = vt[k].av;
      alloc_addr = vt[k].aa;
      @(negedge clk);
      chk({vt[k].nm, "_rdata"}, 128'(rdata), {vt[k].e3, vt[k].e2, vt[k].e1, vt[k].e0});
      chk({vt[k].nm, "_rbusy"}, 128'(rbusy), 128'(vt[k].eb));
      tick();
    end

    // Reset while running: reads go quiet at once, contents and busy bits are cleared
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_all(5'd5);
    @(negedge clk);
    chk("rerst_init_done", 128'(init_done), 128'(1'b0));
    chk("rerst_rdata", 128'(rdata), 128'(0));
    repeat (32) tick();
    raddr = {5'd7, 5'd9, 5'd5, 5'd3};
    @(negedge clk);
    chk("rerst_done", 128'(init_done), 128'(1'b1));
    chk("rerst_cleared", 128'(rdata), 128'(0));
    chk("rerst_busy", 128'(rbusy), 128'(0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
